// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int MID_SAMPLE  = OVERSAMPLE/2 - 1;
  localparam int LAST_SAMPLE = OVERSAMPLE - 1;
  localparam int DATA_BITS   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: head word is readable whenever non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // A pop frees a slot in the same cycle, so push-while-full still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so the output is defined out of reset.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, feeding a show-ahead byte FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rx_pop,
  input  logic                          err_clear,
  output logic                          uart_inbound,
  output logic [7:0]                    uart_data,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun_err
);

  logic                 rx_s1, rxs;
  logic [7:0]           tcnt;
  logic                 tick;
  rx_state_e            state;
  logic [3:0]           sc;
  logic [2:0]           bi;
  logic [DATA_BITS-1:0] shreg;
  logic                 start_det, stop_smp, push, fe_evt, ovr_evt;
  logic                 fifo_full, fifo_empty;

  // Line idles high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  assign start_det = (state == IDLE) && !rxs;
  assign tick      = (tcnt == 8'(BAUD_DIV - 1));

  // Re-phasing on the start edge keeps every sample centred in its bit.
  always_ff @(posedge clk) begin
    if (reset || start_det) tcnt <= '0;
    else if (tick)          tcnt <= '0;
    else                    tcnt <= tcnt + 8'd1;
  end

  assign stop_smp = (state == STOP) && tick && (sc == 4'(LAST_SAMPLE));
  assign push     = stop_smp && rxs;
  assign fe_evt   = stop_smp && !rxs;
  assign ovr_evt  = push && fifo_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sc    <= '0;
      bi    <= '0;
      shreg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            sc    <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (sc == 4'(MID_SAMPLE)) begin
              sc    <= '0;
              bi    <= '0;
              state <= rxs ? IDLE : DATA;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (sc == 4'(LAST_SAMPLE)) begin
              sc    <= '0;
              shreg <= {rxs, shreg[DATA_BITS-1:1]};
              bi    <= bi + 3'd1;
              if (bi == 3'(DATA_BITS - 1)) state <= STOP;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (sc == 4'(LAST_SAMPLE)) begin
              sc    <= '0;
              state <= rxs ? IDLE : WAIT_HIGH;
            end else begin
              sc <= sc + 4'd1;
            end
          end
        end
        // Hold off through a break so a long low line is not re-read as frames.
        WAIT_HIGH: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      frame_err   <= (frame_err   && !err_clear) || fe_evt;
      overrun_err <= (overrun_err && !err_clear) || ovr_evt;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (shreg),
    .pop   (rx_pop),
    .dout  (uart_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign uart_inbound = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at BAUD_DIV=4 (64 clk per bit).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset, rx, rx_pop, err_clear;
  logic       uart_inbound;
  logic [7:0] uart_data;
  logic [2:0] rx_count;
  logic       frame_err, overrun_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .rx_pop       (rx_pop),
    .err_clear    (err_clear),
    .uart_inbound (uart_inbound),
    .uart_data    (uart_data),
    .rx_count     (rx_count),
    .frame_err    (frame_err),
    .overrun_err  (overrun_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_inb"}, uart_inbound, 0);
    chk({tag, "_data"}, uart_data, 8'h00);
    chk({tag, "_cnt"}, rx_count, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_oerr"}, overrun_err, 0);
  endtask

  // One 640-clk frame from a negedge; stop-sample cycle is c=610, so a
  // strobe set at c=610 lands on the edge that pushes.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_at,
                            input int clr_at, input int rst_at, input bit chk_lat);
    int k;
    for (int c = 0; c < 640; c++) begin
      if (chk_lat && c == 610) chk("inb_before_push", uart_inbound, 0);
      if (chk_lat && c == 611) chk("inb_after_push", uart_inbound, 1);
      if (rst_at >= 0 && c == rst_at + 1) chk_rst_vals("midframe_rst");
      k = c / 64;
      rx        = (k == 0) ? 1'b0 : (k == 9) ? stop : b[k-1];
      rx_pop    = (c == pop_at);
      err_clear = (c == clr_at);
      reset     = (c == rst_at);
      @(negedge clk);
    end
    rx_pop = 0; err_clear = 0; reset = 0;
  endtask

  task automatic pop_once();
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  task automatic clear_once();
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
  endtask

  logic [7:0] exp_b;

  initial begin
    reset = 1'b1; rx = 1'b1; rx_pop = 1'b0; err_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst_vals("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // 1: single frame, visibility one cycle after the stop sample
    send_frame(8'hA5, 1'b1, -1, -1, -1, 1'b1);
    chk("t1_data", uart_data, 8'hA5);
    chk("t1_cnt", rx_count, 1);
    chk("t1_ferr", frame_err, 0);
    chk("t1_oerr", overrun_err, 0);
    pop_once();
    chk("t1_inb_popped", uart_inbound, 0);
    chk("t1_cnt_popped", rx_count, 0);

    // 2: 16-clk glitch is rejected at mid start bit
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    chk("t2_cnt", rx_count, 0);
    chk("t2_ferr", frame_err, 0);

    // 3: framing error; clear in the error cycle loses, line held low 5 bits
    send_frame(8'h3C, 1'b0, -1, 610, -1, 1'b0);
    chk("t3_ferr_wins", frame_err, 1);
    repeat (320) @(negedge clk);
    chk("t3_ferr_held", frame_err, 1);
    chk("t3_cnt_low", rx_count, 0);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    chk("t3_cnt_no_retrig", rx_count, 0);
    clear_once();
    chk("t3_ferr_cleared", frame_err, 0);
    send_frame(8'h3C, 1'b1, -1, -1, -1, 1'b0);
    chk("t3_recover_data", uart_data, 8'h3C);
    chk("t3_recover_cnt", rx_count, 1);
    pop_once();

    // 4: overrun with 5 frames into depth 4
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1, -1, 1'b0);
    chk("t4_cnt", rx_count, 4);
    chk("t4_oerr", overrun_err, 1);
    exp_b = 8'h01;
    for (int i = 0; i < 4; i++) begin
      chk("t4_drain", uart_data, exp_b);
      pop_once();
      exp_b = exp_b + 8'h01;
    end
    chk("t4_inb_empty", uart_inbound, 0);
    pop_once();
    chk("t4_pop_empty_cnt", rx_count, 0);
    clear_once();
    chk("t4_oerr_cleared", overrun_err, 0);

    // 5: full FIFO with pop in the stop-sample cycle
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1, -1, 1'b0);
    chk("t5_full", rx_count, 4);
    send_frame(8'h14, 1'b1, 610, -1, -1, 1'b0);
    chk("t5_cnt_kept", rx_count, 4);
    chk("t5_no_oerr", overrun_err, 0);
    exp_b = 8'h11;
    for (int i = 0; i < 3; i++) begin
      chk("t5_drain", uart_data, exp_b);
      pop_once();
      exp_b = exp_b + 8'h01;
    end
    chk("t5_last", uart_data, 8'h14);
    chk("t5_last_cnt", rx_count, 1);

    // 6: reset during data bit 3 of 0xFF; 0x14 still queued is flushed
    send_frame(8'hFF, 1'b1, -1, -1, 280, 1'b0);
    chk("t6_no_partial", rx_count, 0);
    send_frame(8'h5A, 1'b1, -1, -1, -1, 1'b0);
    chk("t6_data", uart_data, 8'h5A);
    chk("t6_cnt", rx_count, 1);
    pop_once();
    chk("t6_cnt_popped", rx_count, 0);
    chk("t6_inb_popped", uart_inbound, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
